regfile_writeback_queue: RTL and testbench

REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 57 +++++
 rtl/regfile_writeback_queue.sv | 112 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and the write-back entry type for the
//               register-file write-back queue.
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

    localparam int DATA_W    = 64;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [REG_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular storage for write-back entries; exposes the raw
//               entry array and head pointer so the top can search it.
// Revision    : 1.0
// ============================================================================
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  i_push,
    input  wb_entry_t             i_pushEntry,
    input  logic                  i_pop,
    output wb_entry_t             o_headEntry,
    output logic [3:0]            o_count,
    output logic [PTR_W-1:0]      o_headPtr,
    output wb_entry_t [DEPTH-1:0] o_entries
);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [3:0]            r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PTR_W'(1);
            if (i_pop)  r_head <= r_head + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (i_push && !Reset) r_mem[r_tail] <= i_pushEntry;
    end

    assign o_headEntry = r_mem[r_head];
    assign o_count     = r_count;
    assign o_headPtr   = r_head;
    assign o_entries   = r_mem;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_queue
// Description : Buffers register write-backs and drains one per cycle into
//               the register-file write port; optional bypass lookup is
//               enabled by macro REGFILE_WB_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
module regfile_writeback_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [REG_IDX_W-1:0] InRW,
    input  logic [DATA_W-1:0]    InData,
    input  logic                 Hold,
    output logic                 RegWr,
    output logic [REG_IDX_W-1:0] RW,
    output logic [DATA_W-1:0]    BusW,
    output logic [3:0]           Count,
    output logic                 Empty,
    output logic                 Full,
    input  logic [REG_IDX_W-1:0] LookupReg,
    output logic                 LookupHit,
    output logic [DATA_W-1:0]    LookupData
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [3:0]            w_count;
    logic [PTR_W-1:0]      w_headPtr;
    wb_entry_t             w_headEntry;
    wb_entry_t             w_pushEntry;
    wb_entry_t [DEPTH-1:0] w_entries;

    assign w_full   = (w_count == 4'(DEPTH));
    assign w_empty  = (w_count == 4'd0);
    assign InReady  = !w_full;
    assign Count    = w_count;
    assign Empty    = w_empty;
    assign Full     = w_full;

    // Zero-register writes complete the handshake but never enter storage.
    assign w_push      = InValid && !w_full && (InRW != ZERO_REG) && !Reset;
    assign w_pop       = !Hold && !w_empty && !Reset;
    assign w_pushEntry = '{idx: InRW, data: InData};

    wb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_pop),
        .o_headEntry (w_headEntry),
        .o_count     (w_count),
        .o_headPtr   (w_headPtr),
        .o_entries   (w_entries)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWr <= 1'b0;
            RW    <= '0;
            BusW  <= '0;
        end else if (w_pop) begin
            RegWr <= 1'b1;
            RW    <= w_headEntry.idx;
            BusW  <= w_headEntry.data;
        end else begin
            RegWr <= 1'b0;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Walk oldest to newest so the last match found is the newest one.
    always_comb begin
        LookupHit  = 1'b0;
        LookupData = '0;
        if (LookupReg != ZERO_REG) begin
            if (RegWr && (RW == LookupReg)) begin
                LookupHit  = 1'b1;
                LookupData = BusW;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if ((4'(k) < w_count) &&
                    (w_entries[w_headPtr + PTR_W'(k)].idx == LookupReg)) begin
                    LookupHit  = 1'b1;
                    LookupData = w_entries[w_headPtr + PTR_W'(k)].data;
                end
            end
        end
    end
`else
    logic w_unused;
    assign w_unused   = &{1'b0, LookupReg, w_entries, w_headPtr};
    assign LookupHit  = 1'b0;
    assign LookupData = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback_queue
// Description : Directed vector bench for regfile_writeback_queue (DEPTH=4).
// Revision    : 1.0
// ============================================================================
module tb_regfile_writeback_queue;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRW;
    logic [63:0] InData;
    logic        Hold;
    logic        RegWr;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic [3:0]  Count;
    logic        Empty;
    logic        Full;
    logic [4:0]  LookupReg;
    logic        LookupHit;
    logic [63:0] LookupData;

    int checks = 0;
    int passed = 0;

    regfile_writeback_queue #(.DEPTH(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .InRW       (InRW),
        .InData     (InData),
        .Hold       (Hold),
        .RegWr      (RegWr),
        .RW         (RW),
        .BusW       (BusW),
        .Count      (Count),
        .Empty      (Empty),
        .Full       (Full),
        .LookupReg  (LookupReg),
        .LookupHit  (LookupHit),
        .LookupData (LookupData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [4:0]  rw;
        logic [63:0] data;
        logic        hold;
        logic        expReady;
        logic        expRegWr;
        logic [4:0]  expRW;
        logic [63:0] expBusW;
        logic [3:0]  expCount;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [4:0] rw,
                         input logic [63:0] data, input logic hold);
        @(negedge Clk);
        Reset   = rst;
        InValid = vld;
        InRW    = rw;
        InData  = data;
        Hold    = hold;
    endtask

    task automatic chkState(input string tag, input logic expRegWr, input logic [4:0] expRW,
                            input logic [63:0] expBusW, input logic [3:0] expCount);
        chk({tag, ".RegWr"}, 64'(RegWr), 64'(expRegWr));
        chk({tag, ".RW"},    64'(RW),    64'(expRW));
        chk({tag, ".BusW"},  BusW,       expBusW);
        chk({tag, ".Count"}, 64'(Count), 64'(expCount));
        chk({tag, ".Empty"}, 64'(Empty), 64'(expCount == 4'd0));
        chk({tag, ".Full"},  64'(Full),  64'(expCount == 4'd4));
    endtask

    logic expHit;
    logic [63:0] expData;

    initial begin
        //             rst vld rw     data     hold rdy wr  RW     BusW     cnt
        // single write then idle
        vecs[0]  = '{0, 1, 5'd3,  64'hA5, 0, 1, 0, 5'd0,  64'h0,  4'd1};
        vecs[1]  = '{0, 0, 5'd0,  64'h0,  0, 1, 1, 5'd3,  64'hA5, 4'd0};
        vecs[2]  = '{0, 0, 5'd0,  64'h0,  0, 1, 0, 5'd3,  64'hA5, 4'd0};
        // zero-register discard
        vecs[3]  = '{0, 1, 5'd31, 64'hFF, 0, 1, 0, 5'd3,  64'hA5, 4'd0};
        vecs[4]  = '{0, 0, 5'd0,  64'h0,  0, 1, 0, 5'd3,  64'hA5, 4'd0};
        // fill under hold, fifth push refused
        vecs[5]  = '{0, 1, 5'd1,  64'h11, 1, 1, 0, 5'd3,  64'hA5, 4'd1};
        vecs[6]  = '{0, 1, 5'd2,  64'h22, 1, 1, 0, 5'd3,  64'hA5, 4'd2};
        vecs[7]  = '{0, 1, 5'd4,  64'h44, 1, 1, 0, 5'd3,  64'hA5, 4'd3};
        vecs[8]  = '{0, 1, 5'd6,  64'h66, 1, 1, 0, 5'd3,  64'hA5, 4'd4};
        vecs[9]  = '{0, 1, 5'd7,  64'h77, 1, 0, 0, 5'd3,  64'hA5, 4'd4};
        // release hold: four back-to-back writes in order
        vecs[10] = '{0, 0, 5'd0,  64'h0,  0, 0, 1, 5'd1,  64'h11, 4'd3};
        vecs[11] = '{0, 0, 5'd0,  64'h0,  0, 1, 1, 5'd2,  64'h22, 4'd2};
        vecs[12] = '{0, 0, 5'd0,  64'h0,  0, 1, 1, 5'd4,  64'h44, 4'd1};
        vecs[13] = '{0, 0, 5'd0,  64'h0,  0, 1, 1, 5'd6,  64'h66, 4'd0};
        vecs[14] = '{0, 0, 5'd0,  64'h0,  0, 1, 0, 5'd6,  64'h66, 4'd0};
        // simultaneous push and pop at Count=2
        vecs[15] = '{0, 1, 5'd8,  64'h88, 1, 1, 0, 5'd6,  64'h66, 4'd1};
        vecs[16] = '{0, 1, 5'd9,  64'h99, 1, 1, 0, 5'd6,  64'h66, 4'd2};
        vecs[17] = '{0, 1, 5'd10, 64'hAA, 0, 1, 1, 5'd8,  64'h88, 4'd2};
        vecs[18] = '{0, 1, 5'd11, 64'hBB, 0, 1, 1, 5'd9,  64'h99, 4'd2};
        vecs[19] = '{0, 0, 5'd0,  64'h0,  0, 1, 1, 5'd10, 64'hAA, 4'd1};
        vecs[20] = '{0, 0, 5'd0,  64'h0,  0, 1, 1, 5'd11, 64'hBB, 4'd0};
        vecs[21] = '{0, 0, 5'd0,  64'h0,  0, 1, 0, 5'd11, 64'hBB, 4'd0};
        // reset mid-drain with a handshake in the reset cycle
        vecs[22] = '{0, 1, 5'd12, 64'hC1, 1, 1, 0, 5'd11, 64'hBB, 4'd1};
        vecs[23] = '{0, 1, 5'd13, 64'hC2, 1, 1, 0, 5'd11, 64'hBB, 4'd2};
        vecs[24] = '{0, 1, 5'd14, 64'hC3, 1, 1, 0, 5'd11, 64'hBB, 4'd3};
        vecs[25] = '{1, 1, 5'd15, 64'hC4, 0, 1, 0, 5'd0,  64'h0,  4'd0};
        vecs[26] = '{0, 0, 5'd0,  64'h0,  0, 1, 0, 5'd0,  64'h0,  4'd0};

        LookupReg = 5'd0;
        drive(1, 0, 5'd0, 64'h0, 0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chkState("reset", 0, 5'd0, 64'h0, 4'd0);
        chk("reset.InReady", 64'(InReady), 64'd1);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].rw, vecs[i].data, vecs[i].hold);
            #1;
            chk($sformatf("v%0d.InReady", i), 64'(InReady), 64'(vecs[i].expReady));
            @(posedge Clk);
            #1;
            chkState($sformatf("v%0d", i), vecs[i].expRegWr, vecs[i].expRW,
                     vecs[i].expBusW, vecs[i].expCount);
        end

        // bypass priority: two queued writes to x5, newest wins
        drive(0, 1, 5'd5, 64'd1, 1);
        @(posedge Clk);
        drive(0, 1, 5'd5, 64'd2, 1);
        @(posedge Clk);
        drive(0, 0, 5'd0, 64'h0, 1);
        LookupReg = 5'd5;
`ifdef REGFILE_WB_BYPASS_EN
        expHit = 1'b1; expData = 64'd2;
`else
        expHit = 1'b0; expData = 64'd0;
`endif
        #1;
        chk("byp.queued.Hit",  64'(LookupHit), 64'(expHit));
        chk("byp.queued.Data", LookupData,     expData);
        LookupReg = 5'd31;
        #1;
        chk("byp.zero.Hit",  64'(LookupHit), 64'd0);
        chk("byp.zero.Data", LookupData,     64'd0);
        LookupReg = 5'd6;
        #1;
        chk("byp.miss.Hit", 64'(LookupHit), 64'd0);

        // drain: after first pop x5=2 still queued, after second only in flight
        LookupReg = 5'd5;
        drive(0, 0, 5'd0, 64'h0, 0);
        @(posedge Clk);
        #1;
        chk("byp.pop1.Data", LookupData, expData);
        @(posedge Clk);
        #1;
        chk("byp.flight.RegWr", 64'(RegWr), 64'd1);
        chk("byp.flight.Hit",   64'(LookupHit), 64'(expHit));
        chk("byp.flight.Data",  LookupData, expData);
        @(posedge Clk);
        #1;
        chk("byp.idle.Hit", 64'(LookupHit), 64'd0);
        chk("byp.idle.Empty", 64'(Empty), 64'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
